// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: MDU_ctrl op codes,
// FSM state encoding and default job lengths.
package mdu_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MADD  = 4'd7;
   localparam logic [3:0] MDU_MADDU = 4'd8;
   localparam logic [3:0] MDU_MSUB  = 4'd9;
   localparam logic [3:0] MDU_MSUBU = 4'd10;

   localparam int MDU_MULT_CYCLES_DEF = 5;
   localparam int MDU_DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for the MDU. Works only on the
// latched op/operands and the current HI/LO; write_en is low when the
// result must not be committed (divide by zero, non-job op codes).
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] result,
   output logic        write_en
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [32:0] a_ext;
   logic signed [32:0] b_ext;
   logic signed [32:0] quo_s;
   logic signed [32:0] rem_s;
   logic        [63:0] acc;

   // Signed division is done in 33 bits so that 0x80000000 / -1 yields
   // +2^31, whose low 32 bits are the required 0x80000000 quotient.
   assign a_ext  = {a[31], a};
   assign b_ext  = {b[31], b};
   assign quo_s  = a_ext / b_ext;
   assign rem_s  = a_ext % b_ext;
   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};
   assign acc    = {hi, lo};

   // Select the result for the latched op and decide whether it commits
   always_comb begin
      result   = 64'd0;
      write_en = 1'b0;
      case (op)
         MDU_MULT:  begin result = prod_s; write_en = 1'b1; end
         MDU_MULTU: begin result = prod_u; write_en = 1'b1; end
         MDU_DIV: begin
            result   = {rem_s[31:0], quo_s[31:0]};
            write_en = (b != 32'd0);
         end
         MDU_DIVU: begin
            result   = {a % b, a / b};
            write_en = (b != 32'd0);
         end
         MDU_MADD:  begin result = acc + prod_s; write_en = 1'b1; end
         MDU_MADDU: begin result = acc + prod_u; write_en = 1'b1; end
         MDU_MSUB:  begin result = acc - prod_s; write_en = 1'b1; end
         MDU_MSUBU: begin result = acc - prod_u; write_en = 1'b1; end
         default:   begin result = 64'd0; write_en = 1'b0; end
      endcase
   end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer owning HI/LO. One job per start pulse,
// timed by a down-counter; done pulses the cycle after the commit edge.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu
// (ops 7..10) as MULT_CYCLES jobs; without it those ops are no-ops.
// fsm_state exposes the sequencer state for observation.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
)(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [3:0]  MDU_ctrl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        md_D,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        stall_md,
   output logic        done,
   output mdu_state_t  fsm_state
);

   mdu_state_t  state;
   logic [3:0]  cnt;
   logic [3:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        busy_q;
   logic        done_q;
   logic        job_start;
   logic [3:0]  job_len;
   logic [63:0] res;
   logic        wr_en;

   mdu_arith u_arith (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
      .hi       (hi_q),
      .lo       (lo_q),
      .result   (res),
      .write_en (wr_en)
   );

   // Decode which op codes launch a multi-cycle job and how long it runs
   always_comb begin
      job_start = 1'b0;
      job_len   = 4'd0;
      case (MDU_ctrl)
         MDU_MULT, MDU_MULTU: begin job_start = 1'b1; job_len = 4'(MULT_CYCLES); end
         MDU_DIV, MDU_DIVU:   begin job_start = 1'b1; job_len = 4'(DIV_CYCLES);  end
`ifdef MDU_MADD_EN
         MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
            job_start = 1'b1;
            job_len   = 4'(MULT_CYCLES);
         end
`else
         MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
            job_start = 1'b0;
            job_len   = 4'd0;
         end
`endif
         default: begin job_start = 1'b0; job_len = 4'd0; end
      endcase
   end

   // Sequencer FSM: launch jobs / mthi / mtlo in IDLE, count down and commit in RUN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         op_q   <= MDU_NONE;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (job_start) begin
                     op_q   <= MDU_ctrl;
                     a_q    <= A;
                     b_q    <= B;
                     cnt    <= job_len;
                     busy_q <= 1'b1;
                     state  <= ST_RUN;
                  end else if (MDU_ctrl == MDU_MTHI) begin
                     hi_q <= A;
                  end else if (MDU_ctrl == MDU_MTLO) begin
                     lo_q <= A;
                  end
               end
            end
            ST_RUN: begin
               // start during RUN is a protocol violation and is ignored
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  if (wr_en) begin
                     hi_q <= res[63:32];
                     lo_q <= res[31:0];
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign fsm_state = state;
   assign stall_md  = md_D & (start | busy_q);

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Sequences the multiply/divide unit in the E stage and owns the HI/LO architectural registers.
- Accepts one operation per start pulse and runs it as a multi-cycle job with a down-counter. Signals busy while running and commits HI/LO on completion.
- Produces the stall request the hazard logic needs when a D-stage mult/div/mfhi/mflo/mthi/mtlo meets an active or starting MDU job.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage holds an MDU instruction this cycle.
- MDU_ctrl  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; other values are no-op.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- md_D  input  1  D-stage instruction is mult/div/mf/mt class.
- busy  output  1  multi-cycle job in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.
- stall_md  output  1  equals md_D & (start | busy); combinational.
- done  output  1  one-cycle pulse on the cycle after HI/LO commit.

Behaviour:
- Reset (async): state IDLE, counter 0, HI=0, LO=0, busy=0, done=0, operand latches 0. An in-flight job is discarded; HI/LO are not committed.
- State IDLE:
  - start with op 1/2 latches A, B, op; loads counter=MULT_CYCLES; goes to RUN.
  - start with op 3/4 does the same with counter=DIV_CYCLES.
  - start with op 5 writes HI=A at that edge; op 6 writes LO=A at that edge. State stays IDLE, busy stays 0.
  - ops 0 and 11..15 do nothing.
- State RUN:
  - busy=1. The counter decrements every cycle.
  - When counter==1, the next edge commits HI/LO, returns to IDLE and raises done for one cycle.
  - busy is high for exactly N cycles starting the cycle after the start edge.
- start while busy=1 is a protocol violation: it is ignored and HI/LO are unaffected. The stall_md path guarantees this never occurs.
- mult: signed 32x32 to 64; HI=product[63:32], LO=product[31:0]. multu: unsigned.
- div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. divu: unsigned.
- 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero: runs the full DIV_CYCLES and sets done, but HI/LO are left unchanged.
- Results are computed from the latched operands. Changes on A/B after the start edge have no effect.
- mfhi/mflo read HI/LO combinationally. The pipeline gets a correct value only because stall_md holds them in D until busy falls.
- done and busy are never high in the same cycle.

Optional Feature:
- MDU_MADD_EN defined:
  - ops 7..10 are legal multi-cycle jobs of MULT_CYCLES.
  - madd/maddu: {HI,LO} += signed/unsigned product, 64-bit wrap.
  - msub/msubu: {HI,LO} -= product, 64-bit wrap.
  - The accumulate uses the HI/LO values at commit time.
- MDU_MADD_EN undefined: ops 7..10 are treated as no-op, exactly like op 0.

Decomposition:
- Shared package holds:
  - the MDU_ctrl op-code constants (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU);
  - the state encoding (ST_IDLE, ST_RUN);
  - the default cycle counts.
- One sub-module, mdu_arith: a purely combinational 64-bit result generator over the latched op/operands and current HI/LO. The sequencer owns all state.

Test Plan:
- Reset mid-job:
  - Stimulus: start mult A=7, B=6; assert Reset at cycle 2; release Reset.
  - Required: busy=0, HI=0, LO=0 immediately on Reset; done never pulses.
- Signed mult:
  - Stimulus: start mult A=0xFFFFFFFE (-2), B=3.
  - Required: busy high cycles 1..5; commit at end of cycle 5; HI=0xFFFFFFFF, LO=0xFFFFFFFA; done high cycle 6.
- Signed div and divide by zero:
  - Stimulus: div A=0xFFFFFFF9 (-7), B=2.
  - Required: after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Stimulus: divu A=5, B=0.
  - Required: HI/LO unchanged; done still pulses.
- mthi then dependent mflo stall:
  - Stimulus: mthi A=0x1234 in IDLE.
  - Required: HI=0x1234 next edge, busy=0.
  - Stimulus: start multu A=B=0xFFFFFFFF with md_D=1 held.
  - Required: stall_md=1 on the start cycle and all 5 busy cycles, 0 after; HI=0xFFFFFFFE, LO=0x00000001.
- Protocol violation:
  - Stimulus: pulse start with mtlo during busy.
  - Required: LO unchanged; the job completes normally.
- With MDU_MADD_EN:
  - Stimulus: HI=0, LO=0xFFFFFFFF; madd A=1, B=1.
  - Required: HI=1, LO=0.
  - Stimulus: same op with MDU_MADD_EN undefined.
  - Required: no busy, HI/LO unchanged.
